// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: registered round-robin arbiter for a shared 4-input mux.
// Issues a one-hot hold-until-release grant and the matching 2-bit mux select.
// Priority rotates to the requester after the last owner on every release.
// Optional feature: define ARB_TIMEOUT_EN to bound ownership to MAX_HOLD
// cycles, with a one-cycle `timeout` pulse on each forced release.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] select,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_reg;
    logic [1:0] own_reg;
    logic [1:0] ptr_reg;

    // Catch illegal hold limits at elaboration rather than in the field.
    if (MAX_HOLD < 2 || MAX_HOLD > (1 << CNT_W)) begin : g_bad_param
        $error("mux4_rr_arbiter: MAX_HOLD must lie in 2..2**CNT_W");
    end

    // Search starts at ptr when idle; on a release the new pointer is own+1,
    // so use that directly to regrant on the same edge without a bubble.
    logic [1:0] base;
    assign base = (state_reg == BUSY) ? own_reg + 2'd1 : ptr_reg;

    // Requests rotated so that bit k is the requester at search position k.
    logic [3:0] rot_req;
    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_rot
        logic [1:0] idx;
        assign idx         = base + 2'(gi);
        assign rot_req[gi] = req[idx];
    end

    // Lowest search position with a pending request wins.
    logic [1:0] pick_off;
    always_comb begin
        pick_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (rot_req[k]) begin
                pick_off = 2'(k);
            end
        end
    end

    logic [1:0] win;
    logic       any_req;
    assign win     = base + pick_off;
    assign any_req = |req;

    // Forced release: owner still requesting but has used up its hold budget.
    logic forced;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt_reg;
    assign forced = (state_reg == BUSY) && req[own_reg]
                    && (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));
`else
    assign forced = 1'b0;
`endif

    logic release_ev;
    logic grant_ev;
    assign release_ev = (state_reg == BUSY) && (!req[own_reg] || forced);
    assign grant_ev   = any_req && ((state_reg == IDLE) || release_ev);

`ifdef ARB_TIMEOUT_EN
    // Hold counter: restarts on every grant, counts each cycle of ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg <= '0;
        end else if (grant_ev) begin
            hold_cnt_reg <= '0;
        end else if (state_reg == BUSY) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
        end
    end
`endif

    // Arbitration FSM with registered grant, select, busy and timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            own_reg   <= 2'd0;
            ptr_reg   <= 2'd0;
            gnt       <= 4'b0000;
            select    <= 2'd0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        state_reg <= BUSY;
                        own_reg   <= win;
                        gnt       <= 4'b0001 << win;
                        select    <= win;
                        busy      <= 1'b1;
                    end
                end
                BUSY: begin
                    if (release_ev) begin
                        ptr_reg <= own_reg + 2'd1;
                        timeout <= forced;
                        if (any_req) begin
                            own_reg <= win;
                            gnt     <= 4'b0001 << win;
                            select  <= win;
                        end else begin
                            // select keeps the last owner so the mux stays quiet.
                            state_reg <= IDLE;
                            gnt       <= 4'b0000;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gnt       <= 4'b0000;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
